// File: rtl/fast_square_sweep_sequencer.sv
// Sweep scheduler for the fast-square receive path: settle/record/step per synthesizer step.
// All outputs registered (change on the edge a state is entered); no backpressure, serial writes always accepted.
module fast_square_sweep_sequencer #(
  parameter logic [6:0]  ADDR_BASE         = 7'd80,
  parameter int          NUM_STEPS_DEFAULT = 32,
  parameter logic [15:0] SETTLE_DEFAULT    = 16'd1000,
  parameter logic [15:0] RECORD_DEFAULT    = 16'd35000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        enable,
  input  logic        sync_in,
  output logic        freq_step_out,
  output logic        rx_reset,
  output logic        rx_next,
  output logic        rx_record,
  output logic        busy,
  output logic [5:0]  step_idx,
  output logic [15:0] sweep_count,
  output logic        sync_err
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_RECORD, S_STEP, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_sync_q;
  logic [15:0] r_settle_cfg, r_record_cfg, r_settle_w, r_record_w, r_cnt;
  logic [5:0]  r_nsteps_cfg, r_nsteps_w;
  logic        r_cont_cfg, r_cont_w;

  logic        w_wr_timing, w_wr_mode, w_arm, w_sync_rise, w_start;
  logic        w_in_sweep, w_abort, w_shadow, w_cnt_done, w_last;
  logic [15:0] w_settle_clamp, w_record_clamp;
  logic [5:0]  w_nsteps_clamp;
  logic        w_rx_reset_nxt, w_record_nxt, w_pulse_nxt, w_busy_nxt;

  assign w_wr_timing = serial_strobe && (serial_addr == ADDR_BASE);
  assign w_wr_mode   = serial_strobe && (serial_addr == 7'(ADDR_BASE + 7'd1));
  assign w_arm       = w_wr_mode && serial_data[9];
  assign w_sync_rise = sync_in && !r_sync_q;
  assign w_start     = enable && (w_sync_rise || w_arm);

  assign w_in_sweep = (r_state == S_SETTLE) || (r_state == S_RECORD) || (r_state == S_STEP);
  assign w_abort    = enable && w_in_sweep && w_sync_rise;
  assign w_shadow   = w_abort || (w_start && ((r_state == S_IDLE) || (r_state == S_WAIT)));

  // Zero-valued settings are clamped to one so every phase lasts at least a cycle.
  assign w_settle_clamp = (r_settle_cfg == 16'd0) ? 16'd1 : r_settle_cfg;
  assign w_record_clamp = (r_record_cfg == 16'd0) ? 16'd1 : r_record_cfg;
  assign w_nsteps_clamp = (r_nsteps_cfg == 6'd0)  ? 6'd1  : r_nsteps_cfg;

  assign w_cnt_done = (r_cnt <= 16'd1);
  assign w_last     = (step_idx == (r_nsteps_w - 6'd1));

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else if (w_shadow) begin
      w_state_nxt = S_SETTLE;
    end else begin
      case (r_state)
        S_SETTLE: if (w_cnt_done) w_state_nxt = S_RECORD;
        S_RECORD: if (w_cnt_done) w_state_nxt = S_STEP;
        S_STEP:   w_state_nxt = w_last ? (r_cont_w ? S_WAIT : S_IDLE) : S_SETTLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_rx_reset_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT);
    w_record_nxt   = (w_state_nxt == S_RECORD);
    w_pulse_nxt    = (w_state_nxt == S_STEP);
    w_busy_nxt     = !w_rx_reset_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      rx_reset      <= 1'b1;
      rx_record     <= 1'b0;
      rx_next       <= 1'b0;
      freq_step_out <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      rx_reset      <= w_rx_reset_nxt;
      rx_record     <= w_record_nxt;
      rx_next       <= w_pulse_nxt;
      freq_step_out <= w_pulse_nxt;
      busy          <= w_busy_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync_q     <= 1'b1;
      r_settle_cfg <= SETTLE_DEFAULT;
      r_record_cfg <= RECORD_DEFAULT;
      r_nsteps_cfg <= 6'(NUM_STEPS_DEFAULT);
      r_cont_cfg   <= 1'b0;
      r_settle_w   <= SETTLE_DEFAULT;
      r_record_w   <= RECORD_DEFAULT;
      r_nsteps_w   <= 6'(NUM_STEPS_DEFAULT);
      r_cont_w     <= 1'b0;
      r_cnt        <= 16'd0;
      step_idx     <= 6'd0;
      sweep_count  <= 16'd0;
      sync_err     <= 1'b0;
    end else begin
      r_sync_q <= sync_in;
      if (w_wr_timing) begin
        r_settle_cfg <= serial_data[15:0];
        r_record_cfg <= serial_data[31:16];
      end
      if (w_wr_mode) begin
        r_nsteps_cfg <= serial_data[5:0];
        r_cont_cfg   <= serial_data[8];
      end
      if (w_abort) sync_err <= 1'b1;
      else if (w_wr_mode && serial_data[10]) sync_err <= 1'b0;

      // Working copies see the pre-write config when a write shares the start cycle.
      if (w_shadow) begin
        r_settle_w <= w_settle_clamp;
        r_record_w <= w_record_clamp;
        r_nsteps_w <= w_nsteps_clamp;
        r_cont_w   <= r_cont_cfg;
      end

      if (!enable) begin
        step_idx <= 6'd0;
      end else if (w_shadow) begin
        r_cnt    <= w_settle_clamp;
        step_idx <= 6'd0;
      end else begin
        case (r_state)
          S_SETTLE: r_cnt <= w_cnt_done ? r_record_w : r_cnt - 16'd1;
          S_RECORD: if (!w_cnt_done) r_cnt <= r_cnt - 16'd1;
          S_STEP: begin
            if (w_last) begin
              step_idx    <= 6'd0;
              sweep_count <= sweep_count + 16'd1;
            end else begin
              step_idx <= step_idx + 6'd1;
              r_cnt    <= r_settle_w;
            end
          end
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fast_square_sweep_sequencer.sv
// Bench for fast_square_sweep_sequencer: step pulses checked against a queue of expected (cycle, step) events.
module tb_fast_square_sweep_sequencer;

  localparam logic [6:0] BASE = 7'd80;
  localparam logic [6:0] MODE = 7'd81;
  localparam int ARM  = 1 << 9;
  localparam int CONT = 1 << 8;
  localparam int CLR  = 1 << 10;

  logic        clock = 1'b0;
  logic        reset, serial_strobe, enable, sync_in;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        freq_step_out, rx_reset, rx_next, rx_record, busy, sync_err;
  logic [5:0]  step_idx;
  logic [15:0] sweep_count;

  fast_square_sweep_sequencer dut (
    .clock(clock), .reset(reset), .serial_strobe(serial_strobe), .serial_addr(serial_addr),
    .serial_data(serial_data), .enable(enable), .sync_in(sync_in),
    .freq_step_out(freq_step_out), .rx_reset(rx_reset), .rx_next(rx_next), .rx_record(rx_record),
    .busy(busy), .step_idx(step_idx), .sweep_count(sweep_count), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int cyc; int idx;} ev_t;
  ev_t q[$];

  typedef struct {int settle; int record; int nsteps; int period; int steps; int rec;} vec_t;
  vec_t tbl[5];

  int errors = 0, checks = 0;
  bit chk_rec = 1'b0;
  int exp_rec = 0, rec_run = 0, exp_sweeps = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every step pulse must match the next queued expectation.
  always @(negedge clock) begin
    ev_t e;
    if (freq_step_out === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_step", freq_step_out, 0);
      end else begin
        e = q.pop_front();
        chk("step_cycle", cyc, e.cyc);
        chk("step_idx_at_step", step_idx, e.idx);
        chk("rx_next_with_step", rx_next, 1);
        chk("rx_record_in_step", rx_record, 0);
      end
    end
    if (rx_record === 1'b1) rec_run++;
    else begin
      if (chk_rec && rec_run > 0) chk("record_len", rec_run, exp_rec);
      rec_run = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [6:0] a, input int d);
    @(negedge clock);
    serial_strobe = 1'b1; serial_addr = a; serial_data = d;
    @(negedge clock);
    serial_strobe = 1'b0;
  endtask

  task automatic push_sweep(input int t, input int p, input int n);
    for (int k = 0; k < n; k++) q.push_back('{t + p - 1 + k * p, k});
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clock);
      i++;
    end
    chk("idle_timeout", busy, 0);
    chk("missing_steps", q.size(), 0);
  endtask

  initial begin
    int t, i;
    reset = 1'b1; enable = 1'b1; sync_in = 1'b1;
    serial_strobe = 1'b0; serial_addr = '0; serial_data = '0;
    cycles(3);
    chk("rst_rx_reset", rx_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_record", rx_record, 0);
    chk("rst_freq_step", freq_step_out, 0);
    chk("rst_rx_next", rx_next, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_sweep_count", sweep_count, 0);
    chk("rst_sync_err", sync_err, 0);
    reset = 1'b0;
    cycles(5);
    chk("sync_high_thru_reset", busy, 0);
    sync_in = 1'b0;
    cycles(2);

    tbl[0] = '{3, 5, 2, 9, 2, 5};
    tbl[1] = '{0, 0, 0, 3, 1, 1};
    tbl[2] = '{1, 2, 3, 4, 3, 2};
    tbl[3] = '{7, 1, 1, 9, 1, 1};
    tbl[4] = '{1, 65535, 1, 65537, 1, 65535};
    chk_rec = 1'b1;
    for (int v = 0; v < 5; v++) begin
      exp_rec = tbl[v].rec;
      wr(BASE, {16'(tbl[v].record), 16'(tbl[v].settle)});
      wr(MODE, tbl[v].nsteps);
      wr(MODE, tbl[v].nsteps | ARM);
      t = cyc;
      push_sweep(t, tbl[v].period, tbl[v].steps);
      chk("busy_after_arm", busy, 1);
      chk("rx_reset_after_arm", rx_reset, 0);
      wait_idle(tbl[v].period * tbl[v].steps + 20);
      exp_sweeps++;
      chk("tbl_sweep_count", sweep_count, exp_sweeps);
      chk("tbl_step_idx_idle", step_idx, 0);
      chk("tbl_rx_reset_idle", rx_reset, 1);
    end

    // Arm in the same write as a new step count: sweep uses the old count.
    exp_rec = 2;
    wr(BASE, {16'd2, 16'd1});
    wr(MODE, 1);
    wr(MODE, 3 | ARM);
    t = cyc;
    push_sweep(t, 4, 1);
    wait_idle(40);
    exp_sweeps++;
    chk("prewrite_sweep_count", sweep_count, exp_sweeps);

    // Continuous mode driven by sync pulses.
    exp_rec = 20;
    wr(BASE, {16'd20, 16'd10});
    wr(MODE, 4 | CONT);
    for (int s = 0; s < 3; s++) begin
      @(negedge clock); sync_in = 1'b1;
      @(negedge clock); t = cyc;
      push_sweep(t, 31, 4);
      cycles(2); sync_in = 1'b0;
      cycles(196);
      exp_sweeps++;
      chk("cont_sweep_count", sweep_count, exp_sweeps);
      chk("cont_wait_busy", busy, 0);
      chk("cont_wait_rx_reset", rx_reset, 1);
      chk("cont_sync_err", sync_err, 0);
      chk("cont_missing_steps", q.size(), 0);
    end

    // Sync edge during RECORD of step 2 aborts and restarts.
    chk_rec = 1'b0;
    wr(BASE, {16'd5, 16'd3});
    wr(MODE, 3);
    wr(MODE, 3 | ARM);
    t = cyc;
    push_sweep(t, 9, 2);
    i = 0;
    while (!(step_idx == 6'd2 && rx_record) && i < 100) begin
      @(negedge clock);
      i++;
    end
    chk("reach_record_step2", rx_record, 1);
    sync_in = 1'b1;
    @(negedge clock); t = cyc;
    chk("abort_sync_err", sync_err, 1);
    chk("abort_step_idx", step_idx, 0);
    chk("abort_rx_record", rx_record, 0);
    chk("abort_busy", busy, 1);
    chk("abort_no_step", freq_step_out, 0);
    chk("abort_sweep_count", sweep_count, exp_sweeps);
    push_sweep(t, 9, 3);
    cycles(3); sync_in = 1'b0;
    wr(MODE, 3 | ARM);
    chk("arm_midsweep_sync_err", sync_err, 1);
    wait_idle(60);
    exp_sweeps++;
    chk("abort_restart_count", sweep_count, exp_sweeps);
    wr(MODE, 3 | CLR);
    chk("sync_err_cleared", sync_err, 0);

    // Timing rewrite mid-sweep applies only to the next sweep.
    chk_rec = 1'b1; exp_rec = 5;
    wr(BASE, {16'd5, 16'd3});
    wr(MODE, 2);
    wr(MODE, 2 | ARM);
    t = cyc;
    push_sweep(t, 9, 2);
    cycles(4);
    wr(BASE, {16'd50, 16'd3});
    wait_idle(40);
    exp_sweeps++;
    exp_rec = 50;
    wr(MODE, 2 | ARM);
    t = cyc;
    push_sweep(t, 54, 2);
    wait_idle(130);
    exp_sweeps++;
    chk("rewrite_sweep_count", sweep_count, exp_sweeps);

    // Enable dropped during SETTLE.
    wr(BASE, {16'd5, 16'd10});
    wr(MODE, 2 | ARM);
    cycles(3);
    enable = 1'b0;
    q.delete();
    @(negedge clock);
    chk("en_busy", busy, 0);
    chk("en_rx_reset", rx_reset, 1);
    chk("en_step_idx", step_idx, 0);
    chk("en_rx_record", rx_record, 0);
    cycles(30);
    chk("en_sweep_count_held", sweep_count, exp_sweeps);
    chk("en_still_idle", busy, 0);
    enable = 1'b1;
    cycles(2);

    // Asynchronous reset mid-RECORD with sync held high across release.
    chk_rec = 1'b0;
    wr(BASE, {16'd20, 16'd3});
    wr(MODE, 1);
    wr(MODE, 1 | ARM);
    i = 0;
    while (!rx_record && i < 20) begin
      @(negedge clock);
      i++;
    end
    chk("reach_record", rx_record, 1);
    cycles(2);
    sync_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("arst_rx_reset", rx_reset, 1);
    chk("arst_rx_record", rx_record, 0);
    chk("arst_busy", busy, 0);
    chk("arst_step_idx", step_idx, 0);
    chk("arst_sweep_count", sweep_count, 0);
    chk("arst_freq_step", freq_step_out, 0);
    q.delete();
    cycles(3);
    reset = 1'b0;
    cycles(10);
    chk("arst_sync_high_no_start", busy, 0);
    chk("arst_rx_reset_held", rx_reset, 1);
    sync_in = 1'b0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fast_square_sweep_sequencer.md
Name: fast_square_sweep_sequencer

Overview:
Programmable sweep scheduler for the fast-square receive path. It steps the external synthesizer through N frequency steps. At each step it applies a settle interval and then a record interval, and it drives the rx_reset, rx_next and rx_record controls of the fast_square_bb baseband blocks. Timing is configured over the serial settings bus. The block sits between serial_io/master_control and the fast_square_bb instances, clocked on clk64.

Parameters:
ADDR_BASE, 7'd80, serial address of the timing register; ADDR_BASE+1 is the mode register
NUM_STEPS_DEFAULT, 32, reset value of num_steps (1..63)
SETTLE_DEFAULT, 16'd1000, reset value of settle ticks
RECORD_DEFAULT, 16'd35000, reset value of record ticks

Ports:
clock  in  1  clk64
reset  in  1  asynchronous, active-high; all state returns to reset values immediately
serial_strobe  in  1  settings write strobe
serial_addr  in  7  settings address
serial_data  in  32  settings data
enable  in  1  sweep permitted; low forces IDLE
sync_in  in  1  debounced external sweep-start level; the rising edge is used
freq_step_out  out  1  one-cycle pulse that advances the synthesizer
rx_reset  out  1  reset to fast_square_bb
rx_next  out  1  one-cycle pulse that advances the fast_square_bb bin
rx_record  out  1  high while fast_square_bb accumulates
busy  out  1  high in SETTLE, RECORD or STEP
step_idx  out  6  current step number
sweep_count  out  16  completed sweeps, wraps at 65535->0
sync_err  out  1  sticky flag: a sync edge arrived mid-sweep

Behaviour:
- Timing register write (addr==ADDR_BASE with serial_strobe):
  - settle = data[15:0]
  - record = data[31:16]
- Mode register write (addr==ADDR_BASE+1 with serial_strobe):
  - num_steps = data[5:0]
  - continuous = data[8]
  - arm = data[9]; arm is a self-clearing one-cycle start request and is not stored
  - data[10]=1 clears sync_err
- Config is shadowed into working copies on each sweep start. Writes during a sweep affect only the next sweep.
- Zero-value clamps applied at shadowing: num_steps 0 -> 1; settle 0 -> 1; record 0 -> 1.
- sync_rise = sync_in & ~sync_q. sync_q resets to 1, so a level held high through reset is not an edge.
- start = enable & (sync_rise | arm).
- Reset values:
  - state IDLE, rx_reset=1
  - freq_step_out, rx_next, rx_record, busy = 0
  - step_idx=0, sweep_count=0, sync_err=0
  - config registers at their defaults; cnt=0
- All outputs are registered; each changes on the cycle the state is entered.
- States:
  - IDLE: rx_reset=1. On start, shadow config, set step_idx=0, load cnt, go to SETTLE.
  - SETTLE: rx_reset=0, rx_record=0. Lasts exactly settle cycles, then go to RECORD and load cnt.
  - RECORD: rx_record=1 for exactly record cycles, then go to STEP.
  - STEP: lasts 1 cycle with rx_next=1, freq_step_out=1, rx_record=0.
    - If step_idx==num_steps-1: sweep_count+1, step_idx=0, then WAIT_SYNC if continuous else IDLE.
    - Otherwise step_idx+1, then SETTLE.
  - WAIT_SYNC: rx_reset=1, busy=0. On start, shadow config and go to SETTLE with step_idx=0. enable low -> IDLE.
- Steady-state period per step = settle + record + 1 cycles.
- sync_rise during SETTLE, RECORD or STEP with enable high:
  - abort the sweep and set sync_err=1
  - reshadow config, set step_idx=0, go directly to SETTLE
  - no STEP pulse; sweep_count is unchanged
- An arm write during a sweep is ignored and does not set sync_err.
- enable low in any state: next cycle IDLE, rx_reset=1, rx_record=0, step_idx=0, no pulses, sweep_count held.
- Same-cycle priority: reset > enable low > sync abort > normal transition.
- A serial write in the same cycle as start: the shadow takes the pre-write value.
- Counter width is 16 bits and cnt never wraps; the max-value case 65535 must work.

Test Plan:
- Reset, then arm with settle=3, record=5, num_steps=2, continuous=0 -> required response:
  - rx_reset falls 1 cycle after arm; rx_record high exactly 5 cycles after 3 settle cycles
  - rx_next/freq_step_out pulse at cycle 9, step_idx 0->1, second step identical
  - return to IDLE; sweep_count=1
- Continuous=1, num_steps=4, sync_in pulses every 200 cycles with settle=10, record=20 -> 4 STEP pulses per sweep, 31-cycle step period, WAIT_SYNC between sweeps, sweep_count increments per sweep, sync_err stays 0.
- sync_in rising during RECORD of step 2 -> sync_err=1, step_idx=0, SETTLE next cycle, no freq_step_out; mode write with data[10]=1 clears sync_err.
- Write settle=0, record=0, num_steps=0, then arm -> SETTLE 1 cycle, RECORD 1 cycle, single STEP pulse, IDLE; step period is 3 cycles.
- Rewrite the timing register mid-sweep (record 5->50) -> the current sweep keeps 5; the next sweep uses 50.
- Drop enable during SETTLE; separately, assert reset asynchronously mid-RECORD -> IDLE on the next edge (enable) or immediately (reset), rx_reset=1, rx_record=0, no pulses, step_idx=0. sync_in held high across reset release gives no start.
